sigma_delta_dac_2ch: RTL

//  Stereo 2nd-order sigma-delta DAC. Sits directly downstream of the 2x FIR interpolator.

---
 rtl/sigma_delta_dac_2ch_pkg.sv | 15 +
 rtl/sd_mod2_ch.sv | 71 +++++++
 rtl/sigma_delta_dac_2ch.sv | 72 +++++++
 3 files changed

// File: rtl/sigma_delta_dac_2ch_pkg.sv
// Shared types and Q1.17 full-scale constants for the stereo sigma-delta DAC.
package sigma_delta_dac_2ch_pkg;

    localparam int SAMPLE_W = 18;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t SD_FS_POS = 18'sh1FFFF;
    localparam sample_t SD_FS_NEG = 18'sh20000;

    function automatic sample_t feedback(input logic bit_in);
        return bit_in ? SD_FS_POS : SD_FS_NEG;
    endfunction

endpackage

// File: rtl/sd_mod2_ch.sv
// One channel of the 2nd-order 1-bit modulator: sample hold, two saturating
// integrators and the quantiser register.
module sd_mod2_ch
    import sigma_delta_dac_2ch_pkg::*;
#(
    parameter int ACC1_W = 22,
    parameter int ACC2_W = 26
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    sample_rdy,
    input  sample_t sample_in,
    input  logic    update,
    input  sample_t x,
    output sample_t x_hold,
    output logic    dout,
    output logic    clip_evt
);

    localparam int S1_W = ACC1_W + 2;
    localparam int S2_W = ACC2_W + 2;

    localparam logic signed [S1_W-1:0] ACC1_MAX = {3'b000, {(ACC1_W-1){1'b1}}};
    localparam logic signed [S1_W-1:0] ACC1_MIN = {3'b111, {(ACC1_W-1){1'b0}}};
    localparam logic signed [S2_W-1:0] ACC2_MAX = {3'b000, {(ACC2_W-1){1'b1}}};
    localparam logic signed [S2_W-1:0] ACC2_MIN = {3'b111, {(ACC2_W-1){1'b0}}};

    logic signed [ACC1_W-1:0] acc1, acc1_next;
    logic signed [ACC2_W-1:0] acc2, acc2_next;
    logic signed [S1_W-1:0]   sum1;
    logic signed [S2_W-1:0]   sum2;
    sample_t                  fb;
    logic                     sat1, sat2;

    // The second integrator deliberately takes the pre-update acc1.
    always_comb begin
        fb   = feedback(dout);
        sum1 = {{2{acc1[ACC1_W-1]}}, acc1}
             + {{(S1_W-SAMPLE_W){x[SAMPLE_W-1]}}, x}
             - {{(S1_W-SAMPLE_W){fb[SAMPLE_W-1]}}, fb};
        sum2 = {{2{acc2[ACC2_W-1]}}, acc2}
             + {{(S2_W-ACC1_W){acc1[ACC1_W-1]}}, acc1}
             - {{(S2_W-SAMPLE_W){fb[SAMPLE_W-1]}}, fb};

        sat1      = (sum1 > ACC1_MAX) || (sum1 < ACC1_MIN);
        sat2      = (sum2 > ACC2_MAX) || (sum2 < ACC2_MIN);
        acc1_next = (sum1 > ACC1_MAX) ? ACC1_MAX[ACC1_W-1:0] :
                    (sum1 < ACC1_MIN) ? ACC1_MIN[ACC1_W-1:0] : sum1[ACC1_W-1:0];
        acc2_next = (sum2 > ACC2_MAX) ? ACC2_MAX[ACC2_W-1:0] :
                    (sum2 < ACC2_MIN) ? ACC2_MIN[ACC2_W-1:0] : sum2[ACC2_W-1:0];
        clip_evt  = update && (sat1 || sat2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_hold <= '0;
            acc1   <= '0;
            acc2   <= '0;
            dout   <= 1'b0;
        end else begin
            if (sample_rdy)
                x_hold <= sample_in;
            if (update) begin
                acc1 <= acc1_next;
                acc2 <= acc2_next;
                dout <= ~acc2_next[ACC2_W-1];
            end
        end
    end

endmodule

// File: rtl/sigma_delta_dac_2ch.sv
// Stereo 2nd-order sigma-delta DAC: shared tick divider, mute gating and
// sticky clip flag around two independent modulator channels.
module sigma_delta_dac_2ch
    import sigma_delta_dac_2ch_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DIV_W   = 5,
    parameter int ACC1_W  = 22,
    parameter int ACC2_W  = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_in_rdy,
    input  logic signed [SAMPLE_W-1:0] sample_in_l,
    input  logic signed [SAMPLE_W-1:0] sample_in_r,
    input  logic                       mute,
    output logic                       dout_l,
    output logic                       dout_r,
    output logic                       tick,
    output logic                       clip
);

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    sample_t          x_hold_l, x_hold_r;
    sample_t          x_l, x_r;
    logic             clip_evt_l, clip_evt_r;

    // The modulators update on the same edge that raises tick.
    always_comb begin
        div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
        x_l      = mute ? '0 : x_hold_l;
        x_r      = mute ? '0 : x_hold_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
            clip    <= 1'b0;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            tick    <= div_last;
            clip    <= clip | clip_evt_l | clip_evt_r;
        end
    end

    sd_mod2_ch #(.ACC1_W(ACC1_W), .ACC2_W(ACC2_W)) u_l (
        .clk        (clk),
        .reset      (reset),
        .sample_rdy (sample_in_rdy),
        .sample_in  (sample_in_l),
        .update     (div_last),
        .x          (x_l),
        .x_hold     (x_hold_l),
        .dout       (dout_l),
        .clip_evt   (clip_evt_l)
    );

    sd_mod2_ch #(.ACC1_W(ACC1_W), .ACC2_W(ACC2_W)) u_r (
        .clk        (clk),
        .reset      (reset),
        .sample_rdy (sample_in_rdy),
        .sample_in  (sample_in_r),
        .update     (div_last),
        .x          (x_r),
        .x_hold     (x_hold_r),
        .dout       (dout_r),
        .clip_evt   (clip_evt_r)
    );

endmodule
